scr1_ahb_mem_slave: RTL and testbench
=====================================

Name: scr1_ahb_mem_slave

Overview:
Synthesizable AHB-Lite responder (slave) memory with a programmable wait-state pattern and ERROR responses. It is the responder end of the core's imem/dmem AHB master ports. It replaces behavioural memory in FPGA and emulation builds. It attaches point-to-point to one master; the single hready signal is driven by this block.

Parameters:
MEM_POWER_SIZE, 12, log2 of memory size in bytes; the array holds 2^(MEM_POWER_SIZE-2) 32-bit words.
STALL_PATTERN_RST, 32'hFFFF_FFFF, wait-state pattern loaded at reset.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
stall_pattern_ld  in  1  one-cycle pulse; loads stall_pattern_in
stall_pattern_in  in  32  new wait-state pattern
hprot  in  4  ignored
hburst  in  3  ignored; only single/INCR accesses are supported
hsize  in  3  transfer size: 0 byte, 1 half, 2 word
htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
haddr  in  SCR1_AHB_WIDTH  byte address
hwrite  in  1  1 = write
hwdata  in  SCR1_AHB_WIDTH  write data, valid in the data phase
hready  out  1  transfer-complete / bus ready
hrdata  out  SCR1_AHB_WIDTH  read data
hresp  out  1  SCR1_HRESP_OKAY / SCR1_HRESP_ERR

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. State = IDLE, hready=1, hresp=OKAY, hrdata=0, pattern register = STALL_PATTERN_RST. Memory contents are not reset.
- rst asserted mid-transfer: return to IDLE next edge; any pending write is dropped (array unchanged).
- Address phase accepted when hready=1 and htrans[1]=1 (NONSEQ/SEQ). BUSY and IDLE are no-transfer.
- On accept, latch haddr, hsize and hwrite, and classify the transfer:
  - error if haddr >= 2^MEM_POWER_SIZE;
  - error if hsize > 2;
  - error if misaligned (half with haddr[0]=1; word with haddr[1:0]!=0).
- FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE:
  - hready=1, hresp=OKAY.
  - Accepted OK transfer -> DATA.
  - Accepted error transfer -> ERR1.
- DATA: each cycle, examine pattern bit 0.
  - Bit 0 = 0: wait state. hready=0, hrdata=0.
  - Bit 0 = 1: completion cycle. hready=1, hresp=OKAY.
    - Read: hrdata = array word (combinational read of the latched word index).
    - Write: the selected byte lanes of hwdata are written at the clock edge.
  - Pattern rotates right by 1 on every DATA cycle.
  - In the completion cycle a new address phase may be accepted (pipelined back-to-back). The next state is DATA/ERR1 for the new transfer, or IDLE if none.
- ERR1: hready=0, hresp=ERR. Always -> ERR2.
- ERR2:
  - hready=1, hresp=ERR. No array access.
  - The next address phase may be accepted here, same rules as IDLE.
- hrdata is 0 outside read completion cycles.
- Byte lanes: byte -> lane haddr[1:0]; half -> lanes {haddr[1],0}..+1; word -> all 4. Reads return the full word; the master extracts lanes.
- Pattern register:
  - stall_pattern_ld loads stall_pattern_in at the edge, overriding that cycle's rotation.
  - An all-zero value is substituted with 32'h1 (prevents deadlock).
- Read after a back-to-back write to the same word returns the new data. This holds because the write commits at the completion edge and the read's completion is at least one cycle later.

Decomposition:
- Reuse the codebase's AHB header constants: SCR1_AHB_WIDTH, SCR1_HRESP_OKAY/ERR, SCR1_HTRANS_*, SCR1_HSIZE_*.
- Local FSM enum and the byte-enable function belong in a small package, scr1_ahb_mem_slave_pkg.
- One sub-module: scr1_mem_be_ram (word array, 4-bit byte-enable write, combinational read).

Test Plan:
- Reset with default pattern; word write 0xDEADBEEF @0x10, then read @0x10 -> each completes in 1 data cycle, hresp=OKAY, hrdata=0xDEADBEEF.
- Pattern 32'b...0101 (alternating); word read -> hready low 1 cycle then high; 4 back-to-back reads alternate 0/1 wait correctly.
- Byte write 0xAA @0x13, half write 0x1234 @0x10 over 0xDEADBEEF -> word read = 0xAAAD1234.
- Misaligned word @0x02, and addr 2^MEM_POWER_SIZE -> 2-cycle ERROR (hready 0/1, hresp 1/1); memory unchanged; next NONSEQ accepted in ERR2 completes OKAY.
- stall_pattern_ld with 0 -> loaded as 32'h1; reads complete on every 32nd data cycle, never hang.
- rst asserted during a write wait state -> hready=1, hresp=OKAY, hrdata=0 next cycle; read of that address returns the old data.

Source files
------------

// File: rtl/scr1_ahb_mem_slave_pkg.sv
// Shared AHB-Lite constants plus the local FSM encoding and byte-lane helper
// for the AHB memory responder.
package scr1_ahb_mem_slave_pkg;

    localparam int SCR1_AHB_WIDTH = 32;

    localparam logic SCR1_HRESP_OKAY = 1'b0;
    localparam logic SCR1_HRESP_ERR  = 1'b1;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } mem_state_e;

    // Byte-lane enables for an aligned transfer of the given size.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SCR1_HSIZE_8B:  be = 4'b0001 << addr_lo;
            SCR1_HSIZE_16B: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_mem_be_ram.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module scr1_mem_be_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [0:(2**ADDR_W)-1];

    // NOTE: the array has no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/scr1_ahb_mem_slave.sv
// AHB-Lite memory responder with a rotating wait-state pattern and two-cycle
// ERROR responses for out-of-range, oversized or misaligned transfers.
module scr1_ahb_mem_slave
    import scr1_ahb_mem_slave_pkg::*;
#(
    parameter int          MEM_POWER_SIZE    = 12,
    parameter logic [31:0] STALL_PATTERN_RST = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_pattern_ld,
    input  logic [31:0]               stall_pattern_in,
    input  logic [3:0]                hprot,
    input  logic [2:0]                hburst,
    input  logic [2:0]                hsize,
    input  logic [1:0]                htrans,
    input  logic [SCR1_AHB_WIDTH-1:0] haddr,
    input  logic                      hwrite,
    input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
    output logic                      hready,
    output logic [SCR1_AHB_WIDTH-1:0] hrdata,
    output logic                      hresp
);

    localparam int          WORD_AW     = MEM_POWER_SIZE - 2;
    localparam logic [31:0] PATTERN_RST = (STALL_PATTERN_RST == 32'h0) ? 32'h1 : STALL_PATTERN_RST;

    mem_state_e         state_q, state_d;
    logic [31:0]        pattern_q, pattern_d;
    logic [WORD_AW-1:0] word_addr_q, word_addr_d;
    logic [3:0]         be_q, be_d;
    logic               write_q, write_d;

    logic               trans_req;
    logic               accept;
    logic               xfer_err;
    logic               data_done;
    logic               ram_we;
    logic [31:0]        ram_rdata;
    mem_state_e         xfer_state;

    logic unused_ok;
    assign unused_ok = ^{hprot, hburst};

    always_comb begin
        case (htrans)
            SCR1_HTRANS_NONSEQ, SCR1_HTRANS_SEQ: trans_req = 1'b1;
            SCR1_HTRANS_IDLE, SCR1_HTRANS_BUSY:  trans_req = 1'b0;
            default:                             trans_req = 1'b0;
        endcase
    end

    // hready depends only on registered state, so using it to qualify accept is loop-free.
    assign data_done = (state_q == ST_DATA) && pattern_q[0];
    assign hready    = (state_q == ST_IDLE) || (state_q == ST_ERR2) || data_done;
    assign accept    = hready && trans_req;

    assign xfer_err = (|haddr[SCR1_AHB_WIDTH-1:MEM_POWER_SIZE])
                   || (hsize > SCR1_HSIZE_32B)
                   || ((hsize == SCR1_HSIZE_16B) && haddr[0])
                   || ((hsize == SCR1_HSIZE_32B) && (haddr[1:0] != 2'b00));

    assign xfer_state = !accept ? ST_IDLE : (xfer_err ? ST_ERR1 : ST_DATA);

    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        be_d        = be_q;
        write_d     = write_q;
        pattern_d   = pattern_q;
        hresp       = SCR1_HRESP_OKAY;
        hrdata      = '0;
        ram_we      = 1'b0;

        if (accept) begin
            word_addr_d = haddr[MEM_POWER_SIZE-1:2];
            be_d        = be_gen(hsize, haddr[1:0]);
            write_d     = hwrite;
        end

        case (state_q)
            ST_IDLE: state_d = xfer_state;
            ST_DATA: begin
                if (pattern_q[0]) begin
                    // A write still pending when rst rises must not reach the array.
                    ram_we  = write_q && !rst;
                    hrdata  = write_q ? '0 : ram_rdata;
                    state_d = xfer_state;
                end
            end
            ST_ERR1: begin
                hresp   = SCR1_HRESP_ERR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = SCR1_HRESP_ERR;
                state_d = xfer_state;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stall_pattern_ld) begin
            pattern_d = (stall_pattern_in == 32'h0) ? 32'h1 : stall_pattern_in;
        end else if (state_q == ST_DATA) begin
            pattern_d = {pattern_q[0], pattern_q[31:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pattern_q   <= PATTERN_RST;
            word_addr_q <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            word_addr_q <= word_addr_d;
            be_q        <= be_d;
            write_q     <= write_d;
        end
    end

    scr1_mem_be_ram #(
        .ADDR_W (WORD_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (be_q),
        .addr_i  (word_addr_q),
        .wdata_i (hwdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_scr1_ahb_mem_slave.sv
// Directed bench for scr1_ahb_mem_slave: transfers, wait-state patterns,
// byte lanes, error responses and mid-transfer reset.
module tb_scr1_ahb_mem_slave;
    import scr1_ahb_mem_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_pattern_ld;
    logic [31:0] stall_pattern_in;
    logic [3:0]  hprot;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    scr1_ahb_mem_slave dut (
        .clk              (clk),
        .rst              (rst),
        .stall_pattern_ld (stall_pattern_ld),
        .stall_pattern_in (stall_pattern_in),
        .hprot            (hprot),
        .hburst           (hburst),
        .hsize            (hsize),
        .htrans           (htrans),
        .haddr            (haddr),
        .hwrite           (hwrite),
        .hwdata           (hwdata),
        .hready           (hready),
        .hrdata           (hrdata),
        .hresp            (hresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic [2:0] sz, input logic wr);
        htrans = SCR1_HTRANS_NONSEQ;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
    endtask

    task automatic idle_bus();
        htrans = SCR1_HTRANS_IDLE;
        haddr  = 32'h0;
        hsize  = 3'b000;
        hwrite = 1'b0;
    endtask

    task automatic load_pattern(input logic [31:0] p);
        stall_pattern_ld = 1'b1;
        stall_pattern_in = p;
        tick();
        stall_pattern_ld = 1'b0;
        stall_pattern_in = 32'h0;
    endtask

    // Runs the data phase up to (not past) the completion cycle; caller drives the next address and ticks.
    task automatic data_ph(input string tag, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] exp_rd);
        hwdata = wdata;
        for (int i = 0; i < waits; i++) begin
            check({tag, "_wait_hready"}, 32'(hready), 32'd0);
            tick();
        end
        check({tag, "_hready"}, 32'(hready), 32'd1);
        check({tag, "_hresp"},  32'(hresp),  32'd0);
        check({tag, "_hrdata"}, hrdata, wr ? 32'h0 : exp_rd);
    endtask

    initial begin
        rst              = 1'b1;
        stall_pattern_ld = 1'b0;
        stall_pattern_in = 32'h0;
        hprot            = 4'h0;
        hburst           = 3'h0;
        hwdata           = 32'h0;
        idle_bus();
        tick();
        tick();
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp",  32'(hresp),  32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        rst = 1'b0;

        // Default all-ones pattern: single-cycle data phases
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b1); tick(); idle_bus();
        data_ph("wr10", 1'b1, 32'hDEAD_BEEF, 0, 32'h0); tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("rd10", 1'b0, 32'h0, 0, 32'hDEAD_BEEF); tick();

        // Alternating pattern: first read sees bit0=1, then each transfer gets one wait
        load_pattern(32'h5555_5555);
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("alt_rd10", 1'b0, 32'h0, 0, 32'hDEAD_BEEF); tick();

        addr_ph(32'h00, SCR1_HSIZE_32B, 1'b1); tick();
        addr_ph(32'h14, SCR1_HSIZE_32B, 1'b1);
        data_ph("b2b_wr00", 1'b1, 32'h0BAD_F00D, 1, 32'h0); tick();
        addr_ph(32'h14, SCR1_HSIZE_32B, 1'b0);
        data_ph("b2b_wr14", 1'b1, 32'h1122_3344, 1, 32'h0); tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0);
        data_ph("b2b_rd14", 1'b0, 32'h0, 1, 32'h1122_3344); tick();
        addr_ph(32'h00, SCR1_HSIZE_32B, 1'b0);
        data_ph("b2b_rd10", 1'b0, 32'h0, 1, 32'hDEAD_BEEF); tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0);
        data_ph("b2b_rd00", 1'b0, 32'h0, 1, 32'h0BAD_F00D); tick();
        idle_bus();
        data_ph("b2b_rd10b", 1'b0, 32'h0, 1, 32'hDEAD_BEEF); tick();

        // Byte and half-word lanes; other lanes of hwdata carry junk
        load_pattern(32'hFFFF_FFFF);
        addr_ph(32'h13, SCR1_HSIZE_8B, 1'b1); tick(); idle_bus();
        data_ph("wr13_b", 1'b1, 32'hAA55_5555, 0, 32'h0); tick();
        addr_ph(32'h10, SCR1_HSIZE_16B, 1'b1); tick(); idle_bus();
        data_ph("wr10_h", 1'b1, 32'h9999_1234, 0, 32'h0); tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("rd10_lanes", 1'b0, 32'h0, 0, 32'hAAAD_1234); tick();

        // Misaligned word write: two-cycle ERROR, next NONSEQ accepted in ERR2
        addr_ph(32'h12, SCR1_HSIZE_32B, 1'b1); tick(); idle_bus();
        hwdata = 32'hFFFF_FFFF;
        check("mis_err1_hready", 32'(hready), 32'd0);
        check("mis_err1_hresp",  32'(hresp),  32'd1);
        tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0);
        check("mis_err2_hready", 32'(hready), 32'd1);
        check("mis_err2_hresp",  32'(hresp),  32'd1);
        tick(); idle_bus();
        data_ph("mis_after_rd10", 1'b0, 32'h0, 0, 32'hAAAD_1234); tick();

        // Out-of-range address 2^12 must not alias onto word 0
        addr_ph(32'h1000, SCR1_HSIZE_32B, 1'b1); tick(); idle_bus();
        hwdata = 32'hFFFF_FFFF;
        check("oor_err1_hready", 32'(hready), 32'd0);
        check("oor_err1_hresp",  32'(hresp),  32'd1);
        tick();
        addr_ph(32'h00, SCR1_HSIZE_32B, 1'b0);
        check("oor_err2_hready", 32'(hready), 32'd1);
        check("oor_err2_hresp",  32'(hresp),  32'd1);
        tick(); idle_bus();
        data_ph("oor_after_rd00", 1'b0, 32'h0, 0, 32'h0BAD_F00D); tick();

        // Oversized transfer
        addr_ph(32'h10, 3'b011, 1'b0); tick(); idle_bus();
        check("size_err1_hready", 32'(hready), 32'd0);
        check("size_err1_hresp",  32'(hresp),  32'd1);
        tick();
        check("size_err2_hresp",  32'(hresp),  32'd1);
        tick();
        check("size_idle_hresp",  32'(hresp),  32'd0);

        // Zero pattern becomes 32'h1: first read immediate, next one waits 31 cycles
        load_pattern(32'h0);
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("zp_rd_a", 1'b0, 32'h0, 0, 32'hAAAD_1234); tick();
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("zp_rd_b", 1'b0, 32'h0, 31, 32'hAAAD_1234); tick();

        // Reset during a write wait state drops the write
        load_pattern(32'h2);
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b1); tick(); idle_bus();
        hwdata = 32'hCAFE_F00D;
        check("rstw_wait_hready", 32'(hready), 32'd0);
        rst = 1'b1;
        tick();
        check("rstw_hready", 32'(hready), 32'd1);
        check("rstw_hresp",  32'(hresp),  32'd0);
        check("rstw_hrdata", hrdata, 32'h0);
        rst = 1'b0;
        addr_ph(32'h10, SCR1_HSIZE_32B, 1'b0); tick(); idle_bus();
        data_ph("rstw_rd10", 1'b0, 32'h0, 0, 32'hAAAD_1234); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
